// File: rtl/sipo_deserializer_if.sv
// Word-assembly bus between a serial bit source and the deserializer.
// Latency: none, wires only.
// Backpressure: none; the source paces bits with bit_en.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic             bit_en;
  logic             din;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             busy;
  logic [CW-1:0]    bit_cnt;

  // Bit source side: drives the serial stream, watches the assembled word.
  modport master (
    output start, bit_en, din,
    input  dout, valid, busy, bit_cnt
  );

  // Deserializer side.
  modport slave (
    input  start, bit_en, din,
    output dout, valid, busy, bit_cnt
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles WIDTH bits into a word.
// Latency: valid/dout appear the cycle after the edge sampling the last bit.
// Backpressure: none; source stalls with bit_en=0, start aborts/restarts.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input logic                 clk,
  input logic                 reset,
  sipo_deserializer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  // Shift register with the incoming bit folded in, in the configured order.
  always_comb begin
    if (MSB_FIRST) shifted = {sreg_q[WIDTH-2:0], bus.din};
    else           shifted = {bus.din, sreg_q[WIDTH-1:1]};
  end

  // Next-state and datapath decode; start always wins over bit_en.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          // Abort: drop the partial word, begin again without leaving SHIFT.
          sreg_d = '0;
          cnt_d  = '0;
        end else if (bus.bit_en) begin
          sreg_d = shifted;
          if (cnt_q == CW'(WIDTH - 1)) begin
            dout_d  = shifted;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        // One-cycle completion slot; start here chains straight into a new word.
        if (bus.start) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs decoded purely from registered state.
  assign bus.dout    = dout_q;
  assign bus.bit_cnt = cnt_q;
  assign bus.valid   = (state_q == DONE);
  assign bus.busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stream.
// Latency: outputs compared 1ns after every rising edge against a bit-queue model.
// Backpressure: stimulus stalls via bit_en gaps and aborts via start.
module tb_sipo_deserializer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic reset;
  logic start, bit_en, din;

  sipo_deserializer_if #(.WIDTH(W), .CW(CW)) bm ();
  sipo_deserializer_if #(.WIDTH(W), .CW(CW)) bl ();

  assign bm.start  = start;
  assign bm.bit_en = bit_en;
  assign bm.din    = din;
  assign bl.start  = start;
  assign bl.bit_en = bit_en;
  assign bl.din    = din;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .CW(CW)) dut_msb (
    .clk(clk), .reset(reset), .bus(bm)
  );
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .CW(CW)) dut_lsb (
    .clk(clk), .reset(reset), .bus(bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nvalid = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;

  // Reference model: bits collected since the last start, plus protocol flags.
  bit       m_busy = 0;
  bit       m_valid = 0;
  bit       bits[$];
  logic [W-1:0] m_msb = '0;
  logic [W-1:0] m_lsb = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_valid = 0;
    bits.delete();
    m_msb = '0;
    m_lsb = '0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic d);
    if (m_busy) begin
      if (s) begin
        bits.delete();
      end else if (b) begin
        bits.push_back(d);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            m_msb[W-1-i] = bits[i];
            m_lsb[i]     = bits[i];
          end
          bits.delete();
          m_busy = 0;
          m_valid = 1;
        end
      end
    end else begin
      m_valid = 0;
      if (s) begin
        m_busy = 1;
        bits.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("msb_valid", 32'(bm.valid), 32'(m_valid));
    chk("msb_busy",  32'(bm.busy),  32'(m_busy));
    chk("msb_cnt",   32'(bm.bit_cnt), 32'(bits.size()));
    chk("msb_dout",  32'(bm.dout),  32'(m_msb));
    chk("lsb_valid", 32'(bl.valid), 32'(m_valid));
    chk("lsb_busy",  32'(bl.busy),  32'(m_busy));
    chk("lsb_cnt",   32'(bl.bit_cnt), 32'(bits.size()));
    chk("lsb_dout",  32'(bl.dout),  32'(m_lsb));
  endtask

  task automatic step(input logic s, input logic b, input logic d);
    start = s;
    bit_en = b;
    din = d;
    @(posedge clk);
    model_edge(s, b, d);
    #1;
    cyc++;
    check_outputs();
    if (bm.valid === 1'b1) begin
      nvalid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
  endtask

  // Sends the word MSB bit first; optional random bit_en-low stalls of 0..5 cycles.
  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 5);
        for (int g = 0; g < n; g++) step(1'b0, 1'b0, 1'($urandom));
      end
      step(1'b0, 1'b1, w[i]);
    end
  endtask

  initial begin
    int n0;
    logic [W-1:0] rnd;
    start = 0; bit_en = 0; din = 0; reset = 0;
    #1 reset = 1;
    #20;
    chk("rst_msb_dout", 32'(bm.dout), 32'h0);
    chk("rst_busy", 32'(bm.busy), 32'h0);
    chk("rst_valid", 32'(bl.valid), 32'h0);
    chk("rst_cnt", 32'(bm.bit_cnt), 32'h0);
    model_reset();
    @(negedge clk) reset = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // MSB-first / LSB-first word 1,0,1,1,0,0,1,0
    n0 = nvalid;
    step(1'b1, 1'b1, 1'b1);
    send_word(8'hB2, 1'b0);
    chk("word_msb", 32'(bm.dout), 32'hB2);
    chk("word_lsb", 32'(bl.dout), 32'h4D);
    chk("word_done_busy", 32'(bm.busy), 32'h0);
    chk("word_done_valid", 32'(bm.valid), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("word_pulses", 32'(nvalid - n0), 32'd1);

    // Same word with random stalls
    n0 = nvalid;
    step(1'b1, 1'b0, 1'b0);
    send_word(8'hB2, 1'b1);
    chk("gap_msb", 32'(bm.dout), 32'hB2);
    chk("gap_lsb", 32'(bl.dout), 32'h4D);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("gap_pulses", 32'(nvalid - n0), 32'd1);

    // Abort after 5 bits with start+bit_en together
    n0 = nvalid;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom));
    step(1'b1, 1'b1, 1'b1);
    chk("abort_cnt", 32'(bm.bit_cnt), 32'd0);
    chk("abort_busy", 32'(bm.busy), 32'd1);
    chk("abort_dout_kept", 32'(bm.dout), 32'hB2);
    chk("abort_no_valid", 32'(nvalid - n0), 32'd0);
    send_word(8'hA5, 1'b0);
    chk("abort_then_msb", 32'(bm.dout), 32'hA5);
    chk("abort_then_lsb", 32'(bl.dout), 32'hA5);
    step(1'b0, 1'b0, 1'b0);
    chk("abort_pulses", 32'(nvalid - n0), 32'd1);

    // Back-to-back words, start held in DONE, bit_en in DONE ignored
    n0 = nvalid;
    step(1'b1, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("b2b_first", 32'(bm.dout), 32'h3C);
    step(1'b1, 1'b1, 1'b1);
    send_word(8'hC3, 1'b0);
    chk("b2b_second", 32'(bm.dout), 32'hC3);
    chk("b2b_second_lsb", 32'(bl.dout), 32'hC3);
    chk("b2b_spacing", 32'(last_vcyc - prev_vcyc), 32'd9);
    chk("b2b_pulses", 32'(nvalid - n0), 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // Asynchronous reset mid-word with three bits received
    step(1'b1, 1'b0, 1'b0);
    rnd = W'($urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd[i]);
    chk("pre_rst_cnt", 32'(bm.bit_cnt), 32'd3);
    reset = 1;
    #2;
    chk("arst_msb_dout", 32'(bm.dout), 32'h0);
    chk("arst_lsb_dout", 32'(bl.dout), 32'h0);
    chk("arst_valid", 32'(bm.valid), 32'h0);
    chk("arst_busy", 32'(bm.busy), 32'h0);
    chk("arst_cnt", 32'(bm.bit_cnt), 32'h0);
    model_reset();
    @(negedge clk) reset = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    chk("post_rst_idle", 32'(bm.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
